cpu16_encode_issue: RTL

- Producer end of the CPU16 instruction-register interface. Converts a one-hot operation select plus register fields into a 16-bit IR word, and presents that word to the decode stage.
- Requests arrive on a valid/ready input port and are buffered in a small FIFO. Words are issued on a valid/ready IR port.
- Illegal operation selects are dropped and flagged. Issued instructions are counted.

---
 rtl/cpu16_encode_issue_if.sv | 29 ++
 rtl/cpu16_encode_issue.sv | 114 +++++++++++
 2 files changed

// File: rtl/cpu16_encode_issue_if.sv
// rtl/cpu16_encode_issue_if.sv - request and IR handshake bundle for cpu16_encode_issue
interface cpu16_encode_issue_if #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic            IN_VALID;
    logic            IN_READY;
    logic [3:0]      ICNT;
    logic [3:0]      DEST;
    logic [3:0]      SRC;
    logic            IR_VALID;
    logic            IR_READY;
    logic [15:0]     IR;
    logic            ERR;
    logic [LW-1:0]   LEVEL;
    logic [CNTW-1:0] ISSUE_CNT;

    modport master (
        output IN_VALID, ICNT, DEST, SRC, IR_READY,
        input  IN_READY, IR_VALID, IR, ERR, LEVEL, ISSUE_CNT
    );

    modport slave (
        input  IN_VALID, ICNT, DEST, SRC, IR_READY,
        output IN_READY, IR_VALID, IR, ERR, LEVEL, ISSUE_CNT
    );
endinterface

// File: rtl/cpu16_encode_issue.sv
// rtl/cpu16_encode_issue.sv - one-hot op encoder feeding a small FIFO that issues CPU16 IR words
module cpu16_encode_issue #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CLR,
    cpu16_encode_issue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [3:0] FUNC_ADD = 4'b1010;
    localparam logic [3:0] FUNC_SUB = 4'b0010;
    localparam logic [3:0] FUNC_AND = 4'b1100;
    localparam logic [3:0] FUNC_OR  = 4'b1110;

    logic [15:0]     mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            err_q, err_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [3:0]  func;
    logic        legal;
    logic [15:0] wr_word_d;
    logic        in_ready;
    logic        ir_valid;
    logic        accept;
    logic        push;
    logic        pop;

    // Anything other than exactly one hot bit (X included) falls to the default arm.
    always_comb begin
        func  = 4'b0000;
        legal = 1'b0;
        case (bus.ICNT)
            4'b0001: begin func = FUNC_ADD; legal = 1'b1; end
            4'b0010: begin func = FUNC_SUB; legal = 1'b1; end
            4'b0100: begin func = FUNC_AND; legal = 1'b1; end
            4'b1000: begin func = FUNC_OR;  legal = 1'b1; end
            default: begin func = 4'b0000;  legal = 1'b0; end
        endcase
    end

    assign wr_word_d = {4'b0000, bus.DEST, func, bus.SRC};

    assign in_ready = (level_q != LW'(DEPTH));
    assign ir_valid = (level_q != '0);
    assign accept   = bus.IN_VALID & in_ready;
    assign push     = accept & legal;
    assign pop      = ir_valid & bus.IR_READY;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        level_d = level_q + LW'(push) - LW'(pop);

        if (accept & ~legal) begin
            err_d = 1'b1;
        end
        if (pop) begin
            cnt_d = cnt_q + CNTW'(1);
        end

        // Clear wins over a same-edge illegal request or issue.
        if (CLR) begin
            err_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage needs no reset: LEVEL gates every read of it.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wptr_q] <= wr_word_d;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.IR_VALID  = ir_valid;
    assign bus.IR        = ir_valid ? mem_q[rptr_q] : 16'h0000;
    assign bus.ERR       = err_q;
    assign bus.LEVEL     = level_q;
    assign bus.ISSUE_CNT = cnt_q;
endmodule
